// File: rtl/ro_trng_ctrl.sv
// ro_trng_ctrl -- sequencer for a ring-oscillator entropy source.
//
// Enables the oscillator, waits out warm-up, samples the raw oscillator
// output through a 2-flop synchroniser at a fixed strobe rate, assembles
// WORD_W-bit words and offers them on a valid/ready port. A repetition-count
// health test on the raw strobe samples shuts the source down when it trips.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous reset, active-low
//   en           level: run the source
//   ro_start     oscillator enable (registered)
//   ro_raw       raw oscillator output, asynchronous to clk
//   rnd_data     random word, stable while rnd_valid=1
//   rnd_valid    word available
//   rnd_ready    consumer accepts; transfer on rnd_valid & rnd_ready
//   health_fail  sticky health-test failure flag (cleared by en=0)
//   busy         high whenever the sequencer is not idle
//
// Build option: define RNG_VN_DEBIAS_EN to insert a Von Neumann corrector
// between the strobe samples and the word assembler. The health test always
// sees the raw samples.
module ro_trng_ctrl #(
  parameter int WORD_W     = 8,
  parameter int WARMUP_CYC = 256,
  parameter int SAMPLE_DIV = 16,
  parameter int REP_LIMIT  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              ro_start,
  input  logic              ro_raw,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              health_fail,
  output logic              busy
);

  localparam int WARM_W = $clog2(WARMUP_CYC) + 1;
  localparam int PSC_W  = $clog2(SAMPLE_DIV) + 1;
  localparam int BIT_W  = $clog2(WORD_W) + 1;
  localparam int REP_W  = $clog2(REP_LIMIT) + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_HOLD    = 3'd3,
    ST_FAIL    = 3'd4
  } state_t;

  state_t              state_r;
  logic                ro_start_r;
  logic [WORD_W-1:0]   rnd_data_r;
  logic                rnd_valid_r;
  logic                health_fail_r;
  logic                busy_r;
  logic [WARM_W-1:0]   warm_cnt_r;
  logic [PSC_W-1:0]    psc_r;
  logic [BIT_W-1:0]    bit_cnt_r;
  logic [WORD_W-2:0]   shift_r;
  logic [REP_W-1:0]    rep_cnt_r;
  logic                prev_r;
  logic                seed_r;
  logic                sync1_r;
  logic                sync2_r;
`ifdef RNG_VN_DEBIAS_EN
  logic                vn_phase_r;
  logic                vn_first_r;
`endif

  logic                sampling_s;
  logic                strobe_s;
  logic [REP_W-1:0]    rep_next_s;
  logic                trip_s;
  logic                accept_s;
  logic                acc_bit_s;
  logic [WORD_W-1:0]   word_s;

  assign ro_start    = ro_start_r;
  assign rnd_data    = rnd_data_r;
  assign rnd_valid   = rnd_valid_r;
  assign health_fail = health_fail_r;
  assign busy        = busy_r;

  // Two-flop synchroniser; sync2_r is the only view of ro_raw inside the block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= ro_raw;
      sync2_r <= sync1_r;
    end
  end

  // Strobe generation, health-count lookahead and accepted-bit selection
  always_comb begin
    sampling_s = (state_r == ST_COLLECT) || (state_r == ST_HOLD);
    strobe_s   = sampling_s && (psc_r == PSC_W'(SAMPLE_DIV - 1));
    rep_next_s = rep_cnt_r;
    if (!strobe_s) begin
      rep_next_s = rep_cnt_r;
    end else if (seed_r || (sync2_r != prev_r)) begin
      rep_next_s = REP_W'(1'b1);
    end else if (rep_cnt_r < REP_W'(REP_LIMIT)) begin
      rep_next_s = rep_cnt_r + REP_W'(1'b1);
    end else begin
      rep_next_s = rep_cnt_r;
    end
    // The trip is decided in the strobe cycle so FAIL beats a same-cycle word or handshake
    trip_s = strobe_s && (rep_next_s == REP_W'(REP_LIMIT));
`ifdef RNG_VN_DEBIAS_EN
    // Second sample of a pair: differing pair yields its first sample as the bit
    accept_s  = strobe_s && vn_phase_r && (vn_first_r != sync2_r);
    acc_bit_s = vn_first_r;
`else
    accept_s  = strobe_s;
    acc_bit_s = sync2_r;
`endif
    word_s = {shift_r, acc_bit_s};
  end

  // Sequencer FSM plus sampling datapath; every output is driven from these flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      ro_start_r    <= 1'b0;
      rnd_data_r    <= {WORD_W{1'b0}};
      rnd_valid_r   <= 1'b0;
      health_fail_r <= 1'b0;
      busy_r        <= 1'b0;
      warm_cnt_r    <= {WARM_W{1'b0}};
      psc_r         <= {PSC_W{1'b0}};
      bit_cnt_r     <= {BIT_W{1'b0}};
      shift_r       <= {(WORD_W-1){1'b0}};
      rep_cnt_r     <= {REP_W{1'b0}};
      prev_r        <= 1'b0;
      seed_r        <= 1'b0;
`ifdef RNG_VN_DEBIAS_EN
      vn_phase_r    <= 1'b0;
      vn_first_r    <= 1'b0;
`endif
    end else begin
      // Prescaler and health history keep running through COLLECT and HOLD
      if (strobe_s) begin
        psc_r     <= {PSC_W{1'b0}};
        rep_cnt_r <= rep_next_s;
        prev_r    <= sync2_r;
        seed_r    <= 1'b0;
`ifdef RNG_VN_DEBIAS_EN
        vn_phase_r <= ~vn_phase_r;
        if (!vn_phase_r) begin
          vn_first_r <= sync2_r;
        end else begin
          vn_first_r <= vn_first_r;
        end
`endif
      end else if (sampling_s) begin
        psc_r <= psc_r + PSC_W'(1'b1);
      end else begin
        psc_r <= psc_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (en) begin
            state_r    <= ST_WARMUP;
            ro_start_r <= 1'b1;
            busy_r     <= 1'b1;
            warm_cnt_r <= {WARM_W{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WARMUP: begin
          if (!en) begin
            state_r    <= ST_IDLE;
            ro_start_r <= 1'b0;
            busy_r     <= 1'b0;
          end else if (warm_cnt_r == WARM_W'(WARMUP_CYC - 1)) begin
            state_r   <= ST_COLLECT;
            psc_r     <= {PSC_W{1'b0}};
            bit_cnt_r <= {BIT_W{1'b0}};
            shift_r   <= {(WORD_W-1){1'b0}};
            rep_cnt_r <= {REP_W{1'b0}};
            prev_r    <= 1'b0;
            seed_r    <= 1'b1;
`ifdef RNG_VN_DEBIAS_EN
            vn_phase_r <= 1'b0;
`endif
          end else begin
            warm_cnt_r <= warm_cnt_r + WARM_W'(1'b1);
          end
        end
        ST_COLLECT: begin
          if (trip_s) begin
            state_r       <= ST_FAIL;
            ro_start_r    <= 1'b0;
            health_fail_r <= 1'b1;
          end else if (!en) begin
            // Partial word is abandoned; bit count restarts on the next run
            state_r    <= ST_IDLE;
            ro_start_r <= 1'b0;
            busy_r     <= 1'b0;
            bit_cnt_r  <= {BIT_W{1'b0}};
          end else if (accept_s) begin
            if (bit_cnt_r == BIT_W'(WORD_W - 1)) begin
              rnd_data_r  <= word_s;
              rnd_valid_r <= 1'b1;
              bit_cnt_r   <= {BIT_W{1'b0}};
              state_r     <= ST_HOLD;
            end else begin
              shift_r   <= word_s[WORD_W-2:0];
              bit_cnt_r <= bit_cnt_r + BIT_W'(1'b1);
            end
          end else begin
            state_r <= ST_COLLECT;
          end
        end
        ST_HOLD: begin
          // Bits accepted here are dropped; only the handshake or a trip leaves HOLD
          if (trip_s) begin
            state_r       <= ST_FAIL;
            ro_start_r    <= 1'b0;
            rnd_valid_r   <= 1'b0;
            health_fail_r <= 1'b1;
          end else if (rnd_ready) begin
            rnd_valid_r <= 1'b0;
            if (en) begin
              state_r <= ST_COLLECT;
`ifdef RNG_VN_DEBIAS_EN
              vn_phase_r <= 1'b0;
`endif
            end else begin
              state_r    <= ST_IDLE;
              ro_start_r <= 1'b0;
              busy_r     <= 1'b0;
            end
          end else begin
            state_r <= ST_HOLD;
          end
        end
        ST_FAIL: begin
          if (!en) begin
            state_r       <= ST_IDLE;
            health_fail_r <= 1'b0;
            busy_r        <= 1'b0;
          end else begin
            state_r <= ST_FAIL;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          ro_start_r    <= 1'b0;
          rnd_valid_r   <= 1'b0;
          health_fail_r <= 1'b0;
          busy_r        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_trng_ctrl.sv
// Self-checking bench for ro_trng_ctrl (WORD_W=8, WARMUP_CYC=4, SAMPLE_DIV=2,
// REP_LIMIT=8). A behavioural reference model works from cycle numbers: the
// warm-up end edge, strobe edges at fixed multiples of SAMPLE_DIV after it,
// and a history of ro_raw per edge (a strobe at edge t sees ro_raw of edge
// t-2 through the synchroniser). Outputs are compared every cycle, plus
// directed checks for the scenarios of interest.
module tb_ro_trng_ctrl;

  localparam int W  = 8;
  localparam int WU = 4;
  localparam int D  = 2;
  localparam int RL = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         ro_raw;
  logic         rnd_ready;
  logic         ro_start;
  logic [W-1:0] rnd_data;
  logic         rnd_valid;
  logic         health_fail;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int t        = 0;
  int raw_mode = 0;   // 0 hold, 1 toggle pattern, 2 random, 3 debias sequence
  int tog_c    = 0;
  bit raw_hist [0:8191];

  // Reference model state
  bit           m_active;
  bit           m_fail;
  bit           m_pending;
  bit           m_seed;
  bit           m_prev;
  int           m_e;
  int           m_run;
  logic [W-1:0] m_word;
  bit           m_bits [$];
`ifdef RNG_VN_DEBIAS_EN
  bit           vn_have;
  bit           vn_first;
  bit [19:0]    vn_seq = 20'b0111_1000_1001_0110_1001;
`endif

  always #5 clk = ~clk;

  ro_trng_ctrl #(.WORD_W(W), .WARMUP_CYC(WU), .SAMPLE_DIV(D), .REP_LIMIT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ro_start(ro_start), .ro_raw(ro_raw),
    .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .health_fail(health_fail), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, want, t);
    end
  endtask

  task model_reset();
    m_active = 0; m_fail = 0; m_pending = 0; m_seed = 0; m_prev = 0;
    m_e = 0; m_run = 0; m_word = '0; m_bits.delete();
`ifdef RNG_VN_DEBIAS_EN
    vn_have = 0; vn_first = 0;
`endif
  endtask

  // Advance the model across one clock edge using the inputs present at that edge
  task model_step();
    bit s;
    bit strobe;
    bit acc;
    bit abit;
    raw_hist[t] = ro_raw;
    if (m_fail) begin
      if (!en) m_fail = 0;
      return;
    end
    if (!m_active) begin
      if (en) begin
        m_active = 1; m_e = t + WU; m_pending = 0; m_seed = 1; m_bits.delete();
`ifdef RNG_VN_DEBIAS_EN
        vn_have = 0;
`endif
      end
      return;
    end
    if (t <= m_e) begin
      if (!en) m_active = 0;
      return;
    end
    strobe = ((t - m_e) % D) == 0;
    s      = raw_hist[t-2];
    acc    = 0;
    abit   = s;
    if (strobe) begin
      if (m_seed || s != m_prev) m_run = 1;
      else if (m_run < RL) m_run++;
      m_prev = s;
      m_seed = 0;
      if (m_run == RL) begin
        m_fail = 1; m_active = 0; m_pending = 0; m_bits.delete();
        return;
      end
`ifdef RNG_VN_DEBIAS_EN
      if (!vn_have) begin
        vn_have = 1; vn_first = s;
      end else begin
        vn_have = 0; acc = (vn_first != s); abit = vn_first;
      end
`else
      acc = 1;
`endif
    end
    if (m_pending) begin
      if (rnd_ready) begin
        m_pending = 0;
`ifdef RNG_VN_DEBIAS_EN
        vn_have = 0;
`endif
        if (!en) m_active = 0;
      end
      return;
    end
    if (!en) begin
      m_active = 0; m_bits.delete();
      return;
    end
    if (acc) begin
      m_bits.push_back(abit);
      if (m_bits.size() == W) begin
        m_word = '0;
        foreach (m_bits[i]) m_word = {m_word[W-2:0], m_bits[i]};
        m_pending = 1;
        m_bits.delete();
      end
    end
  endtask

  // One clock: edge, model update, compare outputs at edge+1, then drive ro_raw
  task tick();
    int tn;
    int k;
    @(posedge clk);
    t++;
    if (!rst_n) begin
      raw_hist[t] = 1'b0;
      model_reset();
    end else begin
      model_step();
    end
    #1;
    chk("ro_start", ro_start, m_active);
    chk("busy", busy, m_active | m_fail);
    chk("rnd_valid", rnd_valid, m_pending);
    chk("health_fail", health_fail, m_fail);
    chk("rnd_data", rnd_data, m_word);
    tog_c++;
    tn = t + 1;
    k  = 0;
    case (raw_mode)
      1: ro_raw = (tog_c < 3) ? 1'b0 : ((((tog_c - 3) / 2) % 2) == 0);
      2: ro_raw = 1'($urandom_range(0, 1));
`ifdef RNG_VN_DEBIAS_EN
      3: begin
        if (m_active && tn >= m_e) k = (tn - m_e + 2) / 2;
        ro_raw = (k >= 1 && k <= 20) ? vn_seq[20-k] : 1'b0;
      end
`endif
      default: ro_raw = ro_raw;
    endcase
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at edge %0d", t);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int words;
    logic [W-1:0] d0;
    rst_n = 1'b0; en = 1'b0; ro_raw = 1'b0; rnd_ready = 1'b0;
    model_reset();
    #2;
    chk("reset_ro_start", ro_start, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_data", rnd_data, 8'h00);
    repeat (2) tick();
    #2 rst_n = 1'b1;
    tick();

    // 1: enable, alternating strobe samples, consumer always ready
    chk("t1_ro_start_pre", ro_start, 1'b0);
    en = 1'b1; rnd_ready = 1'b1; raw_mode = 1; tog_c = 0; ro_raw = 1'b0;
    tick();
    chk("t1_ro_start_c1", ro_start, 1'b1);
    words = 0; n = 0;
    while (words < 3 && n < 200) begin
      if (rnd_valid && rnd_ready) begin
        words++;
`ifndef RNG_VN_DEBIAS_EN
        chk("t1_word_alt", (rnd_data == 8'hAA) || (rnd_data == 8'h55), 1'b1);
`endif
      end
      tick(); n++;
    end
    chk("t1_words_seen", words, 3);
    chk("t1_no_fail", health_fail, 1'b0);

    // 2: back-pressure holds the word for 50 cycles
    rnd_ready = 1'b0;
    n = 0;
    while (!rnd_valid && n < 100) begin tick(); n++; end
    chk("t2_wait_valid", rnd_valid, 1'b1);
    d0 = rnd_data;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("t2_hold_valid", rnd_valid, 1'b1);
      chk("t2_hold_data", rnd_data, d0);
    end
    rnd_ready = 1'b1;
    tick();
    chk("t2_valid_drop", rnd_valid, 1'b0);
    n = 0;
    while (!rnd_valid && n < 100) begin tick(); n++; end
    chk("t2_next_word", rnd_valid, 1'b1);
`ifndef RNG_VN_DEBIAS_EN
    chk("t2_next_alt", (rnd_data == 8'hAA) || (rnd_data == 8'h55), 1'b1);
`endif

    // 3: stuck-at-1 oscillator trips the repetition test
    raw_mode = 0; ro_raw = 1'b1;
    n = 0;
    while (!health_fail && n < 100) begin tick(); n++; end
    chk("t3_fail", health_fail, 1'b1);
    chk("t3_ro_off", ro_start, 1'b0);
    chk("t3_no_valid", rnd_valid, 1'b0);
    repeat (3) tick();
    chk("t3_sticky", health_fail, 1'b1);
    en = 1'b0;
    tick();
    chk("t3_clear", health_fail, 1'b0);
    chk("t3_idle", busy, 1'b0);

    // 4: drop en after three accepted bits, then restart cleanly
    en = 1'b1; raw_mode = 2; rnd_ready = 1'b1;
    n = 0;
    while (m_bits.size() != 3 && n < 200) begin tick(); n++; end
    chk("t4_three_bits", m_bits.size(), 3);
    en = 1'b0;
    tick();
    chk("t4_busy", busy, 1'b0);
    chk("t4_ro_start", ro_start, 1'b0);
    en = 1'b1;
    n = 0;
    while (!rnd_valid && !health_fail && n < 200) begin tick(); n++; end
    chk("t4_progress", rnd_valid | health_fail, 1'b1);
    if (rnd_valid) chk("t4_fresh_word", rnd_data, m_word);

    // Random run: random raw bits, random back-pressure, occasional en drops
    for (int i = 0; i < 600; i++) begin
      if (health_fail) en = 1'b0;
      else en = ($urandom_range(0, 99) != 0);
      rnd_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Bring the block back to IDLE
    en = 1'b0; rnd_ready = 1'b1;
    repeat (3) tick();
    chk("idle_before_t5", busy, 1'b0);

`ifdef RNG_VN_DEBIAS_EN
    // 5: Von Neumann corrector on a fixed pair sequence gives 8'h66
    rnd_ready = 1'b0; raw_mode = 3; en = 1'b1;
    n = 0;
    while (!rnd_valid && n < 200) begin tick(); n++; end
    chk("t5_valid", rnd_valid, 1'b1);
    chk("t5_word", rnd_data, 8'h66);
    en = 1'b0; rnd_ready = 1'b1;
    repeat (3) tick();
`endif

    // 6: asynchronous reset while a word is held
    raw_mode = 1; tog_c = 0; en = 1'b1; rnd_ready = 1'b0;
    n = 0;
    while (!rnd_valid && n < 200) begin tick(); n++; end
    chk("t6_in_hold", rnd_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ro_start", ro_start, 1'b0);
    chk("t6_valid", rnd_valid, 1'b0);
    chk("t6_data", rnd_data, 8'h00);
    chk("t6_fail", health_fail, 1'b0);
    chk("t6_busy", busy, 1'b0);
    model_reset();
    en = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
